// File: rtl/fpmac_stepper_pkg.sv
// Shared types and constants for the FPMAC operand stepper: FSM encoding,
// single-precision constants and the 16-entry operand table.
package fpmac_stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [31:0] ONE  = 32'h3F80_0000;
    localparam logic [31:0] ZERO = 32'h0000_0000;

    localparam int TABLE_DEPTH = 16;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } operand_pair_t;

    function automatic operand_pair_t op_table(input logic [3:0] idx);
        operand_pair_t pair;
        case (idx)
            4'd0:    pair = '{a: ONE,          b: 32'h4000_0000};  // 1.0, 2.0
            4'd1:    pair = '{a: 32'h4040_0000, b: 32'h3F00_0000};  // 3.0, 0.5
            4'd2:    pair = '{a: 32'h4080_0000, b: 32'h3E80_0000};  // 4.0, 0.25
            4'd3:    pair = '{a: 32'h40A0_0000, b: 32'h4020_0000};  // 5.0, 2.5
            4'd4:    pair = '{a: 32'hBF80_0000, b: 32'h4040_0000};  // -1.0, 3.0
            4'd5:    pair = '{a: 32'h4100_0000, b: 32'h3DCC_CCCD};  // 8.0, 0.1
            4'd6:    pair = '{a: 32'h3FC0_0000, b: 32'h3FC0_0000};  // 1.5, 1.5
            4'd7:    pair = '{a: 32'h4120_0000, b: ONE};            // 10.0, 1.0
            4'd8:    pair = '{a: 32'h42C8_0000, b: 32'h3C23_D70A};  // 100.0, 0.01
            4'd9:    pair = '{a: 32'hC000_0000, b: 32'hC000_0000};  // -2.0, -2.0
            4'd10:   pair = '{a: 32'h4049_0FDB, b: ONE};            // pi, 1.0
            4'd11:   pair = '{a: 32'h3F00_0000, b: 32'h3F00_0000};  // 0.5, 0.5
            4'd12:   pair = '{a: 32'h4180_0000, b: 32'h3D80_0000};  // 16.0, 0.0625
            4'd13:   pair = '{a: ZERO,          b: ONE};
            4'd14:   pair = '{a: ONE,           b: ZERO};
            default: pair = '{a: 32'h40E0_0000, b: 32'h3E00_0000};  // 7.0, 0.125
        endcase
        return pair;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level plus a one-cycle
// rising-edge pulse taken from the synchronized side.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic sync3_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
        end else begin
            sync1_reg <= async_in;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~sync3_reg;

endmodule

// File: rtl/fpmac_operand_stepper.sv
// Steps through the operand table one pair per slow_clock rising edge, issuing
// each pair to the FPMAC and latching its result for display.
module fpmac_operand_stepper
    import fpmac_stepper_pkg::*;
#(
    parameter int NUM_OPS        = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       slow_clock,
    input  logic                       run,
    output logic [31:0]                op_a,
    output logic [31:0]                op_b,
    output logic                       op_valid,
    output logic                       acc_clear,
    input  logic                       res_valid,
    input  logic [31:0]                res_data,
    output logic [31:0]                disp_result,
    output logic [$clog2(NUM_OPS)-1:0] op_index,
    output logic                       done,
    output logic                       timeout_err
);

    localparam int IDX_W   = $clog2(NUM_OPS);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_OPS - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t              state_reg;
    state_t              state_next;
    logic [IDX_W-1:0]    op_index_reg;
    logic [TIMER_W-1:0]  timer_reg;
    logic [31:0]         op_a_reg;
    logic [31:0]         op_b_reg;
    logic [31:0]         disp_result_reg;
    logic                step;
    operand_pair_t       table_pair;

    sync_edge_detect u_slow_edge (
        .clock    (clock),
        .reset    (reset),
        .async_in (slow_clock),
        .rise     (step)
    );

    assign table_pair = op_table(4'(op_index_reg));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_valid    = 1'b0;
        acc_clear   = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;

        case (state_reg)
            ST_ISSUE: begin
                op_valid  = 1'b1;
                acc_clear = (op_index_reg == '0);
            end
            ST_DONE: done        = 1'b1;
            ST_ERR:  timeout_err = 1'b1;
            default: ;
        endcase

        // run low overrides every transition, including a pending result
        if (!run) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (step) state_next = ST_ISSUE;
                ST_ISSUE: state_next = ST_WAIT;
                ST_WAIT: begin
                    if (res_valid) begin
                        state_next = (op_index_reg == LAST_IDX) ? ST_DONE : ST_HOLD;
                    end else if (timer_reg == TIMER_LAST) begin
                        state_next = ST_ERR;
                    end
                end
                ST_HOLD:  if (step) state_next = ST_ISSUE;
                default:  state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_a_reg        <= ZERO;
            op_b_reg        <= ZERO;
            disp_result_reg <= ZERO;
            op_index_reg    <= '0;
            timer_reg       <= '0;
        end else begin
            // operands are loaded on entry to ISSUE and then held
            if (state_next == ST_ISSUE) begin
                op_a_reg <= table_pair.a;
                op_b_reg <= table_pair.b;
            end

            if (state_reg == ST_ISSUE) begin
                timer_reg <= '0;
            end else if (state_reg == ST_WAIT) begin
                timer_reg <= timer_reg + 1'b1;
            end

            if (!run) begin
                op_index_reg <= '0;
            end else if (state_reg == ST_WAIT && res_valid) begin
                disp_result_reg <= res_data;
                if (op_index_reg != LAST_IDX) begin
                    op_index_reg <= op_index_reg + 1'b1;
                end
            end
        end
    end

    assign op_a        = op_a_reg;
    assign op_b        = op_b_reg;
    assign disp_result = disp_result_reg;
    assign op_index    = op_index_reg;

endmodule

// File: tb/tb_fpmac_operand_stepper.sv
// Directed bench for fpmac_operand_stepper with a fixed-latency FPMAC stub.
module tb_fpmac_operand_stepper;

    logic        clock = 1'b0;
    logic        reset;
    logic        slow_clock;
    logic        run;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_valid;
    logic        acc_clear;
    logic        res_valid;
    logic [31:0] res_data;
    logic [31:0] disp_result;
    logic [2:0]  op_index;
    logic        done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // stub and monitor state
    int          n_issue = 0;
    int          n_clear = 0;
    int          n_stray_clear = 0;
    int          stub_cd = 0;
    bit          stub_en = 1'b0;
    logic        stub_rv = 1'b0;
    logic [31:0] stub_val = 32'h0;
    logic        man_rv = 1'b0;
    logic [31:0] man_data = 32'h0;

    localparam int STUB_LAT = 4;

    logic [31:0] exp_a [8] = '{32'h3F800000, 32'h40400000, 32'h40800000, 32'h40A00000,
                               32'hBF800000, 32'h41000000, 32'h3FC00000, 32'h41200000};
    logic [31:0] exp_b [8] = '{32'h40000000, 32'h3F000000, 32'h3E800000, 32'h40200000,
                               32'h40400000, 32'h3DCCCCCD, 32'h3FC00000, 32'h3F800000};

    assign res_valid = stub_rv | man_rv;
    assign res_data  = man_rv ? man_data : stub_val;

    fpmac_operand_stepper #(
        .NUM_OPS        (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .slow_clock  (slow_clock),
        .run         (run),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_valid    (op_valid),
        .acc_clear   (acc_clear),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .disp_result (disp_result),
        .op_index    (op_index),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    // FPMAC stub: result strobe STUB_LAT cycles after the issue cycle
    always @(negedge clock) begin
        stub_rv = 1'b0;
        if (stub_cd != 0) begin
            stub_cd = stub_cd - 1;
            if (stub_cd == 0) stub_rv = 1'b1;
        end
        if (acc_clear && !op_valid) n_stray_clear = n_stray_clear + 1;
        if (op_valid) begin
            n_issue = n_issue + 1;
            if (acc_clear) n_clear = n_clear + 1;
            if (stub_en) stub_cd = STUB_LAT;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        reset      = 1'b0;
        run        = 1'b0;
        slow_clock = 1'b0;
        tick(3);
        chk("rst_op_a",        op_a,                32'h0);
        chk("rst_op_b",        op_b,                32'h0);
        chk("rst_disp",        disp_result,         32'h0);
        chk("rst_op_valid",    32'(op_valid),       32'h0);
        chk("rst_acc_clear",   32'(acc_clear),      32'h0);
        chk("rst_op_index",    32'(op_index),       32'h0);
        chk("rst_done",        32'(done),           32'h0);
        chk("rst_timeout",     32'(timeout_err),    32'h0);
        reset = 1'b1;
        tick(2);

        // first issue: edge in cycle k, op_valid in k+3
        run      = 1'b1;
        stub_en  = 1'b1;
        stub_val = 32'h4000_0000;
        slow_clock = 1'b1;
        tick(2);
        chk("first_no_early_issue", 32'(op_valid),  32'h0);
        tick(1);
        chk("first_op_valid",  32'(op_valid),       32'h1);
        chk("first_op_a",      op_a,                32'h3F80_0000);
        chk("first_op_b",      op_b,                32'h4000_0000);
        chk("first_acc_clear", 32'(acc_clear),      32'h1);
        slow_clock = 1'b0;
        tick(4);
        chk("disp_before_res", disp_result,         32'h0);
        chk("index_before_res", 32'(op_index),      32'h0);
        tick(1);
        chk("first_disp",      disp_result,         32'h4000_0000);
        chk("first_op_index",  32'(op_index),       32'h1);
        tick(4);
        chk("hold_no_reissue", 32'(n_issue),        32'h1);
        chk("hold_op_index",   32'(op_index),       32'h1);

        // remaining seven entries; a second edge is dropped during WAIT of entry 2
        for (int i = 1; i < 8; i++) begin
            stub_val   = 32'h4100_0000 + 32'(i);
            slow_clock = 1'b1;
            tick(3);
            chk("seq_op_valid",  32'(op_valid),  32'h1);
            chk("seq_op_a",      op_a,           exp_a[i]);
            chk("seq_op_b",      op_b,           exp_b[i]);
            chk("seq_acc_clear", 32'(acc_clear), 32'h0);
            slow_clock = 1'b0;
            if (i == 2) begin
                tick(1);
                slow_clock = 1'b1;
                tick(1);
                slow_clock = 1'b0;
                tick(3);
            end else begin
                tick(5);
            end
            chk("seq_disp", disp_result, 32'h4100_0000 + 32'(i));
            if (i < 7) begin
                chk("seq_op_index", 32'(op_index), 32'(i + 1));
                chk("seq_not_done", 32'(done),     32'h0);
            end else begin
                chk("seq_done",       32'(done),     32'h1);
                chk("seq_last_index", 32'(op_index), 32'h7);
            end
            tick(4);
            chk("seq_issue_count", 32'(n_issue), 32'(i + 1));
        end
        chk("acc_clear_once",  32'(n_clear),       32'h1);
        chk("acc_clear_stray", 32'(n_stray_clear), 32'h0);

        // ninth edge after DONE is ignored
        slow_clock = 1'b1;
        tick(6);
        slow_clock = 1'b0;
        chk("ninth_no_issue",  32'(n_issue), 32'h8);
        chk("ninth_done_held", 32'(done),    32'h1);
        tick(2);

        run = 1'b0;
        tick(1);
        chk("abort_done_clr",  32'(done),     32'h0);
        chk("abort_index_clr", 32'(op_index), 32'h0);

        // timeout: WAIT entry k+4, timeout_err visible at k+68
        run     = 1'b1;
        stub_en = 1'b0;
        tick(2);
        slow_clock = 1'b1;
        tick(3);
        chk("to_op_valid",  32'(op_valid),  32'h1);
        chk("to_acc_clear", 32'(acc_clear), 32'h1);
        slow_clock = 1'b0;
        tick(64);
        chk("to_not_yet",   32'(timeout_err), 32'h0);
        tick(1);
        chk("to_err_set",   32'(timeout_err), 32'h1);
        run = 1'b0;
        tick(1);
        chk("to_err_clr",   32'(timeout_err), 32'h0);
        chk("to_index_clr", 32'(op_index),    32'h0);

        // result in the expiry cycle wins
        run = 1'b1;
        tick(2);
        slow_clock = 1'b1;
        tick(3);
        chk("tie_op_valid", 32'(op_valid), 32'h1);
        slow_clock = 1'b0;
        tick(64);
        man_data = 32'hC0A0_0000;
        man_rv   = 1'b1;
        tick(1);
        man_rv = 1'b0;
        chk("tie_no_err",   32'(timeout_err), 32'h0);
        chk("tie_disp",     disp_result,      32'hC0A0_0000);
        chk("tie_op_index", 32'(op_index),    32'h1);
        tick(4);
        chk("tie_no_err_later", 32'(timeout_err), 32'h0);

        // stray result while in HOLD is ignored
        man_data = 32'hDEAD_BEEF;
        man_rv   = 1'b1;
        tick(1);
        man_rv = 1'b0;
        tick(1);
        chk("stray_disp",  disp_result,   32'hC0A0_0000);
        chk("stray_index", 32'(op_index), 32'h1);

        // advance to index 3, then reset in the middle of its WAIT
        stub_en  = 1'b1;
        stub_val = 32'h3F80_0000;
        repeat (2) begin
            slow_clock = 1'b1;
            tick(3);
            slow_clock = 1'b0;
            tick(6);
        end
        chk("walk_index3", 32'(op_index), 32'h3);
        slow_clock = 1'b1;
        tick(3);
        chk("idx3_op_valid", 32'(op_valid), 32'h1);
        chk("idx3_op_a",     op_a,          32'h40A0_0000);
        slow_clock = 1'b0;
        tick(2);
        reset = 1'b0;
        #1;
        chk("arst_op_a",      op_a,             32'h0);
        chk("arst_op_b",      op_b,             32'h0);
        chk("arst_disp",      disp_result,      32'h0);
        chk("arst_op_index",  32'(op_index),    32'h0);
        chk("arst_op_valid",  32'(op_valid),    32'h0);
        chk("arst_acc_clear", 32'(acc_clear),   32'h0);
        chk("arst_done",      32'(done),        32'h0);
        chk("arst_timeout",   32'(timeout_err), 32'h0);
        tick(3);
        reset = 1'b1;
        tick(2);

        slow_clock = 1'b1;
        tick(3);
        chk("post_rst_valid", 32'(op_valid),  32'h1);
        chk("post_rst_op_a",  op_a,           32'h3F80_0000);
        chk("post_rst_op_b",  op_b,           32'h4000_0000);
        chk("post_rst_clear", 32'(acc_clear), 32'h1);
        slow_clock = 1'b0;
        tick(6);
        chk("post_rst_disp",  disp_result,    32'h3F80_0000);
        chk("post_rst_index", 32'(op_index),  32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpmac_operand_stepper.md
# fpmac_operand_stepper

Operand sequencer sitting directly downstream of the board clock divider in the FPMAC emulation build. It samples the divider's `slow_clock` as data in the fast domain and advances one step per rising edge. Each step issues one IEEE-754 single-precision operand pair from a fixed table to the pipelined FPMAC, then waits for the result and latches it for the display logic. It turns the human-visible slow tick into single-cycle FPMAC transactions without a second clock domain.

## Interface
Parameters:
- `NUM_OPS`, default 8: number of table entries issued per run, range 2–16.
- `TIMEOUT_CYCLES`, default 64: fast-clock cycles allowed in WAIT before flagging an error, minimum 8.

Ports:
- `clock`  in  1  system clock, the same 100 MHz clock that drives the divider.
- `reset`  in  1  asynchronous, active-low reset.
- `slow_clock`  in  1  divider output; treated as asynchronous data, never used as a clock.
- `run`  in  1  level enable from a board switch; deassertion aborts and rewinds.
- `op_a`  out  32  operand A to the FPMAC.
- `op_b`  out  32  operand B to the FPMAC.
- `op_valid`  out  1  single-cycle issue strobe.
- `acc_clear`  out  1  clears the FPMAC accumulator; asserted only together with the index-0 issue.
- `res_valid`  in  1  FPMAC result strobe.
- `res_data`  in  32  FPMAC accumulated result.
- `disp_result`  out  32  last captured result.
- `op_index`  out  $clog2(NUM_OPS)  index of the next or current operand pair.
- `done`  out  1  all NUM_OPS results captured.
- `timeout_err`  out  1  FPMAC failed to answer within TIMEOUT_CYCLES.

## Operation
- Edge detect: two-flop synchronizer on `slow_clock`, then a third flop. `step` = sync2 & ~sync3, one fast cycle wide.
- States: IDLE, ISSUE, WAIT, HOLD, DONE, ERR.
- IDLE: `op_index`=0. On `step` && `run`, go to ISSUE.
- ISSUE: lasts exactly one cycle.
  - `op_valid`=1; `op_a`/`op_b` = table[`op_index`].
  - `acc_clear`=1 iff `op_index`==0.
  - Clear the timer and go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - On `res_valid`: `disp_result`<=`res_data`. If `op_index`==NUM_OPS-1, go to DONE; otherwise increment `op_index` and go to HOLD.
  - If the timer reaches TIMEOUT_CYCLES-1 without `res_valid`, go to ERR.
- HOLD: on `step`, go to ISSUE.
- DONE: `done`=1 and hold.
- ERR: `timeout_err`=1 and hold.
- `run` low in any state: IDLE on the next cycle, with `op_index`=0, `done`=0, `timeout_err`=0. `disp_result` is retained.
- `op_a`/`op_b` hold their last issued value between issues. The FPMAC must qualify them with `op_valid`.

## Timing
- Reset values: state IDLE; all sync flops 0; `op_a`=`op_b`=`disp_result`=0; `op_valid`=`acc_clear`=`done`=`timeout_err`=0; `op_index`=0; timer 0.
- Latency from a `slow_clock` rising edge to `step`: 2–3 fast cycles, depending on synchronizer metastability resolution.
- `step` at cycle t gives `op_valid` during t+1 and WAIT from t+2.
- `res_valid` at cycle t gives `disp_result` and `op_index` updated, visible at t+1.
- `step` during ISSUE, WAIT, DONE or ERR is dropped, not queued.
- `res_valid` outside WAIT is ignored, including late results after an abort or error.
- `res_valid` in the same cycle as timer expiry: the result wins and no error is raised.
- `run` low in the same cycle as ISSUE: `op_valid` still completes that cycle, and the state is IDLE next.
- Reset asserted mid-WAIT: all outputs return to reset values immediately, asynchronously.

## Structure
- Package `fpmac_stepper_pkg`:
  - State encoding constants.
  - The 16-entry operand table as 32-bit hex constants, with entry 0 = {0x3F800000, 0x40000000} (1.0, 2.0) and entry 1 = {0x40400000, 0x3F000000} (3.0, 0.5).
  - FP constants ONE=0x3F800000 and ZERO=0x00000000.
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus rising-edge pulse. Reused for board switches.
- Timer width: $clog2(TIMEOUT_CYCLES).

## Test plan
- Reset, then `run`=1 and one `slow_clock` rise. Expected: exactly one `op_valid` with `op_a`=0x3F800000, `op_b`=0x40000000, `acc_clear`=1, 3–4 cycles after the edge.
- Stub FPMAC with latency 4 returning 0x40000000. Expected: `disp_result`=0x40000000 one cycle after `res_valid`, `op_index`=1, state HOLD.
- Eight `slow_clock` rises with the latency-4 stub. Expected: 8 issues, `acc_clear` only on the first, `done`=1 after the 8th result; a 9th edge produces no `op_valid`.
- Stub never answers. Expected: `timeout_err`=1 exactly TIMEOUT_CYCLES cycles after WAIT entry. Then `run`=0: `timeout_err`=0 next cycle and `op_index`=0.
- Second `slow_clock` edge during WAIT. Expected: dropped, with no extra `op_valid`. `res_valid` coinciding with timer expiry: result captured, `timeout_err` stays 0.
- Assert `reset` low mid-WAIT with `op_index`=3. Expected: all outputs zero immediately. After release, the next step reissues index 0 with `acc_clear`=1.
